booth_mult_seq: RTL



---
 rtl/booth_pkg.sv | 35 +++
 rtl/booth_mult_seq_pp_gen.sv | 38 +++
 rtl/booth_mult_seq.sv | 85 ++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
// Digit codes, FSM states and the triplet-to-digit recoder.
package booth_pkg;

  localparam int BOOTH_ITER = 17;
  localparam int PROD_W     = 64;

  typedef enum logic [2:0] {
    ZERO = 3'b000,
    POS1 = 3'b001,
    POS2 = 3'b010,
    NEG1 = 3'b101,
    NEG2 = 3'b110
  } digit_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic digit_t booth_digit(input logic [2:0] t);
    digit_t d;
    d = ZERO;
    unique case (t)
      3'b000, 3'b111: d = ZERO;
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_mult_seq_pp_gen.sv
// Combinational Booth partial-product generator:
// digit(triplet) * aext, shifted left by 2*idx.
module booth_pp_gen
  import booth_pkg::*;
(
  input  logic [2:0]        triplet,
  input  logic [PROD_W-1:0] aext,
  input  logic [4:0]        idx,
  output logic [PROD_W-1:0] pp
);

  digit_t            digit;
  logic [PROD_W-1:0] mag;
  logic              neg;

  assign digit = booth_digit(triplet);

  always_comb begin
    mag = '0;
    neg = 1'b0;
    unique case (digit)
      ZERO: mag = '0;
      POS1: mag = aext;
      POS2: mag = aext << 1;
      NEG1: begin
        mag = aext;
        neg = 1'b1;
      end
      NEG2: begin
        mag = aext << 1;
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    pp = (neg ? (~mag + 64'd1) : mag) << {idx, 1'b0};
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one partial product per clock.
// Define BOOTH_EARLY_EXIT_EN to stop once remaining digits are all zero.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Start,
  input  logic                 Sign,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product
);

  state_t            state;
  logic [PROD_W-1:0] aext;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] acc_nxt;
  logic [PROD_W-1:0] pp;
  // {Bext, b(-1)}; arithmetic right shift keeps bsh[2:0] as the triplet
  logic [34:0]       bsh;
  logic [4:0]        cnt;
  logic              last;
  logic              finish;

  booth_pp_gen u_pp (
    .triplet (bsh[2:0]),
    .aext    (aext),
    .idx     (cnt),
    .pp      (pp)
  );

  assign acc_nxt = acc + pp;
  assign last    = (cnt == 5'(BOOTH_ITER - 1));

`ifdef BOOTH_EARLY_EXIT_EN
  assign finish = last | (&bsh[34:2]) | ~(|bsh[34:2]);
`else
  assign finish = last;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Product <= '0;
      acc     <= '0;
      cnt     <= '0;
      aext    <= '0;
      bsh     <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            aext  <= Sign ? {{32{A[31]}}, A} : {32'h0, A};
            bsh   <= {{2{Sign & B[31]}}, B, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          bsh <= {bsh[34], bsh[34], bsh[34:2]};
          cnt <= cnt + 5'd1;
          if (finish) begin
            Product <= acc_nxt;
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
